// File: rtl/asteroids_pkg.sv
// Shared constants and types for the asteroids datapath: screen geometry,
// coordinate widths, colours and the bullet tracker state encoding.
package asteroids_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [X_W-1:0] SCREEN_W = 8'd160;
    localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

    localparam int HIT_W = 8;
    localparam int HIT_H = 8;

    localparam logic [2:0] BULLET_COLOUR = 3'b111;
    localparam logic [2:0] BG_COLOUR     = 3'b000;

    typedef enum logic [1:0] {
        BT_IDLE  = 2'd0,
        BT_ERASE = 2'd1,
        BT_DRAW  = 2'd2,
        BT_HIT   = 2'd3
    } bt_state_t;

endpackage

// File: rtl/bbox_hit.sv
// Combinational point-in-box test. Box end coordinates are formed one bit
// wider than the inputs so boxes touching the far edge never wrap.
module bbox_hit #(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int BOX_W = 8,
    parameter int BOX_H = 8
) (
    input  logic [XW-1:0] px,
    input  logic [YW-1:0] py,
    input  logic [XW-1:0] box_x,
    input  logic [YW-1:0] box_y,
    input  logic          enable,
    output logic          hit
);

    logic [XW:0] x_end;
    logic [YW:0] y_end;
    logic        in_x;
    logic        in_y;

    always_comb begin
        x_end = {1'b0, box_x} + (XW+1)'(BOX_W);
        y_end = {1'b0, box_y} + (YW+1)'(BOX_H);
        in_x  = (px >= box_x) && ({1'b0, px} < x_end);
        in_y  = (py >= box_y) && ({1'b0, py} < y_end);
        hit   = enable && in_x && in_y;
    end

endmodule

// File: rtl/bullet_tracker.sv
// Turns the bullet position stream into erase/draw pixel writes on the shared
// VGA port and reports hits against the live asteroid's bounding box.
module bullet_tracker
    import asteroids_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic [X_W-1:0] bullet_x,
    input  logic [Y_W-1:0] bullet_y,
    input  logic           bullet_plot,
    input  logic           bullet_firing,
    input  logic [X_W-1:0] target_x,
    input  logic [Y_W-1:0] target_y,
    input  logic           target_alive,
    input  logic           bus_grant,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot,
    output logic           collision,
    output logic           hit_pulse,
    output bt_state_t      state_dbg
);

    bt_state_t      state_q, state_d;
    logic [X_W-1:0] last_x_q, last_x_d;
    logic [Y_W-1:0] last_y_q, last_y_d;
    logic [X_W-1:0] pend_x_q, pend_x_d;
    logic [Y_W-1:0] pend_y_q, pend_y_d;
    logic           drawn_q, drawn_d;
    logic           pend_valid_q, pend_valid_d;
    logic           hit_pend_q, hit_pend_d;
    logic           hit_pulse_q, hit_pulse_d;

    logic           new_hit;
    logic           on_screen;
    logic           moved;

    bbox_hit #(
        .XW    (X_W),
        .YW    (Y_W),
        .BOX_W (HIT_W),
        .BOX_H (HIT_H)
    ) u_bbox_hit (
        .px     (bullet_x),
        .py     (bullet_y),
        .box_x  (target_x),
        .box_y  (target_y),
        .enable (target_alive),
        .hit    (new_hit)
    );

    always_comb begin
        state_d      = state_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        drawn_d      = drawn_q;
        pend_valid_d = pend_valid_q;
        hit_pend_d   = hit_pend_q;
        hit_pulse_d  = 1'b0;

        on_screen = (bullet_x < SCREEN_W) && (bullet_y < SCREEN_H);
        moved     = !drawn_q || (bullet_x != last_x_q) || (bullet_y != last_y_q);

        case (state_q)
            BT_IDLE: begin
                // Ceasing fire takes priority over any simultaneous move.
                if (drawn_q && !bullet_firing) begin
                    state_d      = BT_ERASE;
                    pend_valid_d = 1'b0;
                    hit_pend_d   = 1'b0;
                end else if (bullet_firing && bullet_plot && moved) begin
                    pend_x_d     = bullet_x;
                    pend_y_d     = bullet_y;
                    pend_valid_d = on_screen;
                    hit_pend_d   = new_hit;
                    if (drawn_q) begin
                        state_d = BT_ERASE;
                    end else if (new_hit) begin
                        state_d     = BT_HIT;
                        hit_pulse_d = 1'b1;
                    end else if (on_screen) begin
                        state_d = BT_DRAW;
                    end
                end
            end
            BT_ERASE: begin
                if (bus_grant) begin
                    drawn_d = 1'b0;
                    if (hit_pend_q) begin
                        state_d     = BT_HIT;
                        hit_pulse_d = 1'b1;
                    end else if (pend_valid_q) begin
                        state_d = BT_DRAW;
                    end else begin
                        state_d = BT_IDLE;
                    end
                end
            end
            BT_DRAW: begin
                if (bus_grant) begin
                    last_x_d = pend_x_q;
                    last_y_d = pend_y_q;
                    drawn_d  = 1'b1;
                    state_d  = BT_IDLE;
                end
            end
            BT_HIT: begin
                hit_pend_d = 1'b0;
                if (!bullet_firing) begin
                    state_d = BT_IDLE;
                end
            end
            default: state_d = BT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= BT_IDLE;
            last_x_q     <= '0;
            last_y_q     <= '0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            drawn_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            hit_pend_q   <= 1'b0;
            hit_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            drawn_q      <= drawn_d;
            pend_valid_q <= pend_valid_d;
            hit_pend_q   <= hit_pend_d;
            hit_pulse_q  <= hit_pulse_d;
        end
    end

    // Outputs decode only flopped state, so they hold steady while stalled.
    always_comb begin
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = BG_COLOUR;
        if (state_q == BT_ERASE) begin
            vga_plot   = 1'b1;
            vga_x      = last_x_q;
            vga_y      = last_y_q;
            vga_colour = BG_COLOUR;
        end else if (state_q == BT_DRAW) begin
            vga_plot   = 1'b1;
            vga_x      = pend_x_q;
            vga_y      = pend_y_q;
            vga_colour = BULLET_COLOUR;
        end
        collision = (state_q == BT_HIT);
        hit_pulse = hit_pulse_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_bullet_tracker.sv
// Directed bench for bullet_tracker: draw, move, stalled grant, hits,
// edge boxes, cease fire and reset during a write.
module tb_bullet_tracker;
    import asteroids_pkg::*;

    logic           clk;
    logic           resetn;
    logic [X_W-1:0] bullet_x;
    logic [Y_W-1:0] bullet_y;
    logic           bullet_plot;
    logic           bullet_firing;
    logic [X_W-1:0] target_x;
    logic [Y_W-1:0] target_y;
    logic           target_alive;
    logic           bus_grant;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;
    logic           collision;
    logic           hit_pulse;
    bt_state_t      state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    bullet_tracker dut (
        .clk           (clk),
        .resetn        (resetn),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_plot   (bullet_plot),
        .bullet_firing (bullet_firing),
        .target_x      (target_x),
        .target_y      (target_y),
        .target_alive  (target_alive),
        .bus_grant     (bus_grant),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .collision     (collision),
        .hit_pulse     (hit_pulse),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {plot, x, y, colour}
    function automatic logic [31:0] vga_word(input logic p, input logic [7:0] x,
                                             input logic [6:0] y, input logic [2:0] c);
        return {13'd0, p, x, y, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_vga(input string tag, input logic p, input logic [7:0] x,
                             input logic [6:0] y, input logic [2:0] c);
        check(tag, {13'd0, vga_plot, vga_x, vga_y, vga_colour}, vga_word(p, x, y, c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn        = 1'b0;
        bullet_x      = '0;
        bullet_y      = '0;
        bullet_plot   = 1'b0;
        bullet_firing = 1'b0;
        target_x      = '0;
        target_y      = '0;
        target_alive  = 1'b0;
        bus_grant     = 1'b0;
        #1;
        check_vga("reset_vga", 1'b0, 8'd0, 7'd0, 3'd0);
        check("reset_coll", {31'd0, collision}, 32'd0);
        check("reset_pulse", {31'd0, hit_pulse}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, {30'd0, BT_IDLE});
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // First draw
        bullet_firing = 1'b1;
        bullet_plot   = 1'b1;
        bullet_x      = 8'd80;
        bullet_y      = 7'd60;
        bus_grant     = 1'b1;
        check_vga("idle_before_sample", 1'b0, 8'd0, 7'd0, 3'd0);
        tick();
        check_vga("first_draw", 1'b1, 8'd80, 7'd60, 3'b111);
        check("first_draw_coll", {31'd0, collision}, 32'd0);
        tick();
        check_vga("first_draw_done", 1'b0, 8'd0, 7'd0, 3'd0);
        tick();
        check_vga("same_pos_no_write", 1'b0, 8'd0, 7'd0, 3'd0);

        // Move one pixel
        bullet_x = 8'd81;
        tick();
        check_vga("move_erase", 1'b1, 8'd80, 7'd60, 3'b000);
        tick();
        check_vga("move_draw", 1'b1, 8'd81, 7'd60, 3'b111);
        tick();
        check_vga("move_done", 1'b0, 8'd0, 7'd0, 3'd0);

        // Grant stall during erase; intermediate position skipped
        bullet_x  = 8'd82;
        bus_grant = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_vga("stall_erase_hold", 1'b1, 8'd81, 7'd60, 3'b000);
            if (i == 0) bullet_x = 8'd83;
            tick();
        end
        check_vga("stall_erase_end", 1'b1, 8'd81, 7'd60, 3'b000);
        bus_grant = 1'b1;
        tick();
        check_vga("stall_draw_82", 1'b1, 8'd82, 7'd60, 3'b111);
        tick();
        check_vga("stall_idle", 1'b0, 8'd0, 7'd0, 3'd0);
        tick();
        check_vga("latest_erase_82", 1'b1, 8'd82, 7'd60, 3'b000);
        tick();
        check_vga("latest_draw_83", 1'b1, 8'd83, 7'd60, 3'b111);
        tick();

        // Hit with a drawn bullet
        target_x     = 8'd100;
        target_y     = 7'd50;
        target_alive = 1'b1;
        bullet_x     = 8'd99;
        bullet_y     = 7'd52;
        tick();
        tick();
        check_vga("near_miss_draw", 1'b1, 8'd99, 7'd52, 3'b111);
        check("near_miss_coll", {31'd0, collision}, 32'd0);
        tick();
        bullet_x = 8'd100;
        tick();
        check_vga("hit_erase", 1'b1, 8'd99, 7'd52, 3'b000);
        check("hit_erase_coll", {31'd0, collision}, 32'd0);
        tick();
        check_vga("hit_no_draw", 1'b0, 8'd0, 7'd0, 3'd0);
        check("hit_coll_rise", {31'd0, collision}, 32'd1);
        check("hit_pulse_on", {31'd0, hit_pulse}, 32'd1);
        check("hit_state", {30'd0, state_dbg}, {30'd0, BT_HIT});
        tick();
        check("hit_coll_held", {31'd0, collision}, 32'd1);
        check("hit_pulse_off", {31'd0, hit_pulse}, 32'd0);
        tick();
        check("hit_coll_held2", {31'd0, collision}, 32'd1);
        bullet_firing = 1'b0;
        tick();
        check("hit_coll_clear", {31'd0, collision}, 32'd0);
        check_vga("hit_exit_idle", 1'b0, 8'd0, 7'd0, 3'd0);

        // Edge box, undrawn bullet: hit straight from idle
        target_x      = 8'd156;
        target_y      = 7'd116;
        bullet_x      = 8'd159;
        bullet_y      = 7'd119;
        bullet_firing = 1'b1;
        tick();
        check("edge_hit_coll", {31'd0, collision}, 32'd1);
        check("edge_hit_pulse", {31'd0, hit_pulse}, 32'd1);
        check_vga("edge_hit_no_write", 1'b0, 8'd0, 7'd0, 3'd0);
        bullet_firing = 1'b0;
        tick();
        check("edge_hit_clear", {31'd0, collision}, 32'd0);

        // Far from edge box: plain draw
        bullet_x      = 8'd3;
        bullet_y      = 7'd3;
        bullet_firing = 1'b1;
        tick();
        check_vga("edge_miss_draw", 1'b1, 8'd3, 7'd3, 3'b111);
        check("edge_miss_coll", {31'd0, collision}, 32'd0);
        tick();

        // Cease fire: one erase only
        bullet_firing = 1'b0;
        bullet_x      = 8'd4;
        tick();
        check_vga("cease_erase", 1'b1, 8'd3, 7'd3, 3'b000);
        tick();
        check_vga("cease_idle", 1'b0, 8'd0, 7'd0, 3'd0);
        tick();
        check_vga("cease_no_more", 1'b0, 8'd0, 7'd0, 3'd0);

        // Box whose 8-bit / 7-bit end would wrap
        target_x      = 8'd250;
        target_y      = 7'd124;
        bullet_x      = 8'd252;
        bullet_y      = 7'd125;
        bullet_firing = 1'b1;
        tick();
        check("wrap_box_hit", {31'd0, collision}, 32'd1);
        bullet_firing = 1'b0;
        tick();
        check("wrap_box_clear", {31'd0, collision}, 32'd0);

        // Off-screen, no hit: nothing happens
        target_alive  = 1'b0;
        bullet_x      = 8'd200;
        bullet_y      = 7'd10;
        bullet_firing = 1'b1;
        tick();
        check_vga("offscreen_no_write", 1'b0, 8'd0, 7'd0, 3'd0);
        check("offscreen_no_coll", {31'd0, collision}, 32'd0);

        // Dead target inside box, then reset mid-draw
        target_x  = 8'd10;
        target_y  = 7'd10;
        bullet_x  = 8'd10;
        bullet_y  = 7'd10;
        bus_grant = 1'b0;
        tick();
        check_vga("dead_target_draw", 1'b1, 8'd10, 7'd10, 3'b111);
        check("dead_target_coll", {31'd0, collision}, 32'd0);
        tick();
        check_vga("draw_stalled", 1'b1, 8'd10, 7'd10, 3'b111);
        resetn = 1'b0;
        #1;
        check_vga("reset_mid_draw", 1'b0, 8'd0, 7'd0, 3'd0);
        check("reset_mid_coll", {31'd0, collision}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
